// File: rtl/brom_stream_reader.sv
// Streams a contiguous address range out of a registered-read block ROM
// over valid/ready. Optional running checksum port: BROM_STREAM_READER_CHECKSUM_EN.
module brom_stream_reader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
`ifdef BROM_STREAM_READER_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0] checksum,
`endif
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [LEN_WIDTH-1:0]   issue_rem;
   logic                   inflight;
   logic                   inflight_last;
   logic                   skid_valid;
   logic                   skid_last;
   logic [DATA_WIDTH-1:0]  skid_data;
   logic                   accept_c;
   logic                   issue_c;
   logic                   pop_c;
   logic [1:0]             fill_c;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // Issue only when the word returning next cycle is guaranteed a buffer slot.
   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      pop_c      = m_valid & m_ready;
      fill_c     = 2'(m_valid) + 2'(skid_valid) + 2'(inflight);
      issue_c    = (state == S_RUN) && (issue_rem != '0) &&
                   ((fill_c < 2'd2) || ((fill_c == 2'd2) && pop_c));
      case (state)
         S_IDLE: begin
            if (start) begin
               accept_c   = 1'b1;
               next_state = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN:   if (issue_c && (issue_rem == LEN_WIDTH'(1))) next_state = S_DRAIN;
         S_DRAIN: if (pop_c && m_last) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy          <= 1'b0;
         done          <= 1'b0;
         rom_addr      <= '0;
         issue_rem     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         busy          <= (next_state == S_RUN) || (next_state == S_DRAIN);
         done          <= (next_state == S_DONE);
         inflight      <= issue_c;
         inflight_last <= issue_c && (issue_rem == LEN_WIDTH'(1));
         if (accept_c && (length != '0)) begin
            rom_addr  <= base_addr;
            issue_rem <= length;
         end else if (issue_c) begin
            rom_addr  <= rom_addr + ADDR_WIDTH'(1);
            issue_rem <= issue_rem - LEN_WIDTH'(1);
         end
      end
   end

   // Two-entry buffer: the output register is the head, skid holds the second word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
      end else if (pop_c) begin
         if (skid_valid) begin
            m_data <= skid_data;
            m_last <= skid_last;
            if (inflight) begin
               skid_data <= rom_data;
               skid_last <= inflight_last;
            end else begin
               skid_valid <= 1'b0;
            end
         end else if (inflight) begin
            m_data <= rom_data;
            m_last <= inflight_last;
         end else begin
            m_valid <= 1'b0;
         end
      end else if (inflight) begin
         if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= rom_data;
            m_last  <= inflight_last;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= rom_data;
            skid_last  <= inflight_last;
         end
      end
   end

`ifdef BROM_STREAM_READER_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        checksum <= '0;
      else if (accept_c) checksum <= '0;
      else if (pop_c)    checksum <= checksum + m_data;
   end
`endif

endmodule

// File: tb/tb_brom_stream_reader.sv
// Bench for brom_stream_reader: directed scenarios plus random commands,
// checked every cycle against a queue-based expected-beat model.
module tb_brom_stream_reader;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
`ifdef BROM_STREAM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int            total;
   int            bad;
   logic [DW-1:0] rom_mem [1024];
   bit            rnd_ready;

   brom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
`ifdef BROM_STREAM_READER_CHECKSUM_EN
      .checksum  (checksum),
`endif
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural ROM with one-cycle registered read.
   always @(posedge clock) rom_data <= rom_mem[rom_addr];

   always @(posedge clock) begin
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_le(input string name, input longint act, input longint lim);
      total++;
      if (act > lim) begin
         bad++;
         $display("FAIL %s: got %0d expected at most %0d at %0t", name, act, lim, $time);
      end
   endtask

   // Reference model state, owned by the compare process.
   beat_t         exp_q [$];
   logic [DW-1:0] xfer_log [$];
   logic [AW-1:0] addr_log [$];
   bit            exp_busy, exp_done, prev_stall, lat_armed, last_xfer, nxt_busy, nxt_done;
   int            since_acc, xfers, issued;
   logic [AW-1:0] acc_base, zero_addr;
   logic [AW:0]   acc_len;
   logic [DW-1:0] sum_model;
   beat_t         fr;

   always @(negedge clock) begin
      if (!reset) begin
         exp_q.delete();
         exp_busy   = 1'b0;
         exp_done   = 1'b0;
         prev_stall = 1'b0;
         lat_armed  = 1'b0;
         xfers      = 0;
         sum_model  = '0;
         acc_len    = '0;
      end else begin
         chk("done", longint'(done), longint'(exp_done));
         chk("busy", longint'(busy), longint'(exp_busy));
`ifdef BROM_STREAM_READER_CHECKSUM_EN
         chk("checksum", longint'(checksum), longint'(sum_model));
`endif
         if (prev_stall) chk("valid_held", longint'(m_valid), 1);
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got data %h with no beat expected at %0t", m_data, $time);
            end else begin
               chk("m_data", longint'(m_data), longint'(exp_q[0].data));
               chk("m_last", longint'(m_last), longint'(exp_q[0].last));
            end
         end
         if (lat_armed) begin
            since_acc++;
            if (m_valid || since_acc > 3) begin
               chk("first_valid_latency", since_acc, 3);
               lat_armed = 1'b0;
            end
         end
         if (exp_busy && acc_len != '0) begin
            issued = int'(AW'(rom_addr - acc_base));
            chk_le("reads_outstanding", issued - xfers, 2);
            if (acc_len < LW'(1024)) chk_le("reads_issued", issued, longint'(acc_len));
         end
         if (exp_done) begin
            if (acc_len == '0) chk("rom_addr_len0", longint'(rom_addr), longint'(zero_addr));
            else chk("rom_addr_final", longint'(AW'(rom_addr - acc_base)), longint'(AW'(acc_len)));
            chk("beats_left", exp_q.size(), 0);
         end
         last_xfer = 1'b0;
         if (m_valid && m_ready && exp_q.size() != 0) begin
            fr = exp_q.pop_front();
            xfers++;
            sum_model += m_data;
            xfer_log.push_back(m_data);
            last_xfer = fr.last;
         end
         prev_stall = m_valid && !m_ready;
         nxt_done   = last_xfer;
         nxt_busy   = exp_busy && !last_xfer;
         if (start && !exp_busy && !exp_done) begin
            acc_base  = base_addr;
            acc_len   = length;
            xfers     = 0;
            sum_model = '0;
            zero_addr = rom_addr;
            for (int i = 0; i < int'(length); i++)
               exp_q.push_back('{last: (i == int'(length) - 1),
                                 data: rom_mem[AW'(int'(base_addr) + i)]});
            if (length == '0) nxt_done = 1'b1;
            else begin
               nxt_busy  = 1'b1;
               lat_armed = 1'b1;
               since_acc = 0;
            end
         end
         exp_busy = nxt_busy;
         exp_done = nxt_done;
      end
   end

   // Issue one command and wait (bounded) for done; optionally re-pulse start mid-command.
   task automatic run_cmd(input int b, input int len, input bit rr, input int poke_at, input int budget);
      bit seen;
      xfer_log.delete();
      addr_log.delete();
      rnd_ready = rr;
      start     = 1'b1;
      base_addr = AW'(b);
      length    = LW'(len);
      @(posedge clock); #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (addr_log.size() == 0 || addr_log[$] != rom_addr) addr_log.push_back(rom_addr);
         if (c == poke_at) begin
            start     = 1'b1;
            base_addr = AW'(b + 100);
            length    = LW'(5);
         end else begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
         else begin
            @(posedge clock); #1;
         end
      end
      start = 1'b0;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL cmd_timeout: base %0d len %0d got no done, expected within %0d cycles", b, len, budget);
      end
      rnd_ready = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic expect_log(input string tag, input int n,
                             input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                             input logic [DW-1:0] w4, input logic [DW-1:0] w5,
                             input logic [DW-1:0] w6, input logic [DW-1:0] w7);
      logic [DW-1:0] w [8];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      w[4] = w4; w[5] = w5; w[6] = w6; w[7] = w7;
      chk({tag, "_count"}, xfer_log.size(), n);
      for (int i = 0; i < n; i++)
         if (i < xfer_log.size()) chk(tag, longint'(xfer_log[i]), longint'(w[i]));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, longint'(busy), 0);
      chk({tag, "_done"}, longint'(done), 0);
      chk({tag, "_m_valid"}, longint'(m_valid), 0);
      chk({tag, "_m_last"}, longint'(m_last), 0);
      chk({tag, "_rom_addr"}, longint'(rom_addr), 0);
      chk({tag, "_m_data"}, longint'(m_data), 0);
`ifdef BROM_STREAM_READER_CHECKSUM_EN
      chk({tag, "_checksum"}, longint'(checksum), 0);
`endif
   endtask

   initial begin
      int b;
      int l;
      total     = 0;
      bad       = 0;
      reset     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      m_ready   = 1'b1;
      rnd_ready = 1'b0;
      for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
      rom_mem[0] = 16'hC1A1; rom_mem[1] = 16'hA2B2; rom_mem[2] = 16'hDAC3; rom_mem[3] = 16'hFCD4;
      rom_mem[4] = 16'h12E5; rom_mem[5] = 16'h03F6; rom_mem[6] = 16'h2117; rom_mem[7] = 16'h4428;

      repeat (3) @(posedge clock);
      #1;
      chk_zero("reset");
      reset = 1'b1;
      @(posedge clock); #1;

      run_cmd(0, 8, 1'b0, -1, 60);
      expect_log("s1_beats", 8, 16'hC1A1, 16'hA2B2, 16'hDAC3, 16'hFCD4,
                 16'h12E5, 16'h03F6, 16'h2117, 16'h4428);
`ifdef BROM_STREAM_READER_CHECKSUM_EN
      chk("s1_checksum", longint'(checksum), 64'hB804);
`endif

      run_cmd(1022, 4, 1'b0, -1, 60);
      chk("s2_addr_count_min", longint'(addr_log.size() >= 4), 1);
      if (addr_log.size() >= 4) begin
         chk("s2_addr0", longint'(addr_log[0]), 1022);
         chk("s2_addr1", longint'(addr_log[1]), 1023);
         chk("s2_addr2", longint'(addr_log[2]), 0);
         chk("s2_addr3", longint'(addr_log[3]), 1);
      end
      expect_log("s2_beats", 4, 16'h0000, 16'h0000, 16'hC1A1, 16'hA2B2, 0, 0, 0, 0);

      run_cmd(2, 4, 1'b1, -1, 200);
      expect_log("s3_beats", 4, 16'hDAC3, 16'hFCD4, 16'h12E5, 16'h03F6, 0, 0, 0, 0);

      run_cmd(7, 0, 1'b0, -1, 20);
      chk("s4_beats_count", xfer_log.size(), 0);

      run_cmd(0, 8, 1'b0, 3, 60);
      expect_log("s5_beats", 8, 16'hC1A1, 16'hA2B2, 16'hDAC3, 16'hFCD4,
                 16'h12E5, 16'h03F6, 16'h2117, 16'h4428);

      xfer_log.delete();
      start     = 1'b1;
      base_addr = '0;
      length    = LW'(8);
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 0; c < 50 && xfers < 3; c++) begin
         @(posedge clock); #1;
      end
      chk("s6_beats_before_reset", xfers, 3);
      #1;
      reset = 1'b0;
      #1;
      chk_zero("s6_async");
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("s6_no_done", longint'(done), 0);
      run_cmd(4, 2, 1'b0, -1, 30);
      expect_log("s6_beats", 2, 16'h12E5, 16'h03F6, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 1024; i++) rom_mem[i] = DW'($urandom);
      for (int k = 0; k < 25; k++) begin
         b = (k % 4 == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
         l = int'($urandom_range(0, 40));
         run_cmd(b, l, 1'($urandom_range(0, 1)), (k % 5 == 1) ? 2 : -1, l * 20 + 60);
      end
      run_cmd(500, 1024, 1'b0, -1, 1200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
